// File: rtl/counter_ctrl.sv
// counter_ctrl
// Drives the load/enable side of a small up-counter. It accepts a command
// (start value, number of terminal counts to run), loads the counter, and
// enables it until the requested number of tc pulses has been seen. A shadow
// copy of the expected count is compared against count_out on every run cycle.
// A mismatch sets a sticky err flag.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_load, cmd_wraps   start value and number of tc pulses to run for
//   abort                 cancel a run in LOAD or RUN
//   ld_enb, data_in       counter load strobe and load value
//   count_enb             counter enable
//   count_out, tc         counter value and terminal-count flag
//   busy, done            run in progress / one-cycle end-of-run pulse
//   err, wraps_seen       sticky mismatch flag, tc pulses counted this run
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a command, cmd_ready high
// S_LOAD | one cycle: ld_enb high, shadow count seeded with the load value
// S_RUN  | counter enabled, count_out checked, tc pulses counted
// S_DONE | one cycle: done pulse, counter disabled

module counter_ctrl #(
  parameter int CNT_W  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_load,
  input  logic [WRAP_W-1:0] cmd_wraps,
  input  logic              abort,
  output logic              ld_enb,
  output logic [CNT_W-1:0]  data_in,
  output logic              count_enb,
  input  logic [CNT_W-1:0]  count_out,
  input  logic              tc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WRAP_W-1:0] wraps_seen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  load_q, load_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [WRAP_W-1:0] seen_q, seen_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] seen_inc;

  // Saturating increment of the tc counter.
  assign seen_inc = (seen_q == '1) ? seen_q : seen_q + WRAP_W'(1);

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    exp_d   = exp_q;
    wraps_d = wraps_q;
    seen_d  = seen_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          load_d  = cmd_load;
          wraps_d = cmd_wraps;
          seen_d  = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          exp_d   = load_q;
          state_d = (wraps_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // On abort err and wraps_seen are frozen: no compare, no tc count.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (count_out != exp_q) err_d = 1'b1;
          exp_d = exp_q + CNT_W'(1);
          if (tc) begin
            seen_d = seen_inc;
            if (seen_inc == wraps_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_q  <= '0;
      exp_q   <= '0;
      wraps_q <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      exp_q   <= exp_d;
      wraps_q <= wraps_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only, so they never depend on inputs
  // in the same cycle. The load strobe keeps count_enb high as well; the
  // counter gives the load priority.
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign ld_enb     = (state_q == S_LOAD);
  assign count_enb  = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign data_in    = load_q;
  assign err        = err_q;
  assign wraps_seen = seen_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl. A behavioural 3-bit counter is wired to the
// controller. A cycle-level reference model tracks the run in terms of the
// cycle index since command acceptance. Directed table, hand-written corner
// sequences and a randomized phase follow.
module tb_counter_ctrl;
  localparam int CNT_W  = 3;
  localparam int WRAP_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_load;
  logic [WRAP_W-1:0] cmd_wraps;
  logic              abort;
  logic              ld_enb;
  logic [CNT_W-1:0]  data_in;
  logic              count_enb;
  logic [CNT_W-1:0]  count_out;
  logic              tc;
  logic              busy;
  logic              done;
  logic              err;
  logic [WRAP_W-1:0] wraps_seen;

  counter_ctrl #(.CNT_W(CNT_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_wraps(cmd_wraps), .abort(abort),
    .ld_enb(ld_enb), .data_in(data_in), .count_enb(count_enb),
    .count_out(count_out), .tc(tc),
    .busy(busy), .done(done), .err(err), .wraps_seen(wraps_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       ld;
    logic       enb;
    logic       done;
    logic       err;
    logic [7:0] seen;
    logic [2:0] din;
  } outs_t;

  typedef struct {
    bit       v;
    bit [2:0] load;
    bit [7:0] wraps;
    bit       ab;
    bit       rs;
    bit       ready, busy, ld, enb, done, err;
    int       seen;
    int       cnt;
  } vec_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc_n = 0;
  bit    mdl_chk = 1'b0;
  outs_t snap;
  bit [2:0] snap_cnt;
  bit [2:0] cnt = 3'd0;

  // Reference model state: run position counted from the accept cycle.
  bit       m_active = 1'b0;
  int       m_cyc = 0;
  int       m_done_cyc = -1;
  bit [2:0] m_load = 3'd0;
  int       m_wraps = 0;
  int       m_seen = 0;
  bit       m_err = 1'b0;

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.ready = cmd_ready; o.busy = busy; o.ld = ld_enb; o.enb = count_enb;
    o.done = done; o.err = err; o.seen = wraps_seen; o.din = data_in;
    return o;
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    o = '0;
    o.din  = m_load;
    o.err  = m_err;
    o.seen = 8'(m_seen);
    if (!m_active) begin
      o.ready = 1'b1;
    end else begin
      o.busy = 1'b1;
      if (m_cyc == 1) begin
        o.ld = 1'b1; o.enb = 1'b1;
      end else if (m_cyc == m_done_cyc) begin
        o.done = 1'b1;
      end else begin
        o.enb = 1'b1;
      end
    end
    return o;
  endfunction

  // One clock cycle: drive inputs at negedge, check, then advance the
  // counter and the model on the rising edge. fc >= 0 forces the counter.
  task automatic step(input bit v, input bit [2:0] ld, input bit [7:0] w,
                      input bit ab, input bit rs, input int fc);
    bit [2:0] cv;
    bit       tv;
    @(negedge clk);
    if (fc >= 0) cnt = 3'(fc);
    cmd_valid = v; cmd_load = ld; cmd_wraps = w; abort = ab; rst_n = !rs;
    count_out = cnt; tc = (cnt == 3'd7);
    cv = cnt; tv = (cnt == 3'd7);
    snap = sample();
    snap_cnt = cnt;
    if (mdl_chk) chkv($sformatf("model@%0d", cyc_n), {15'b0, snap}, {15'b0, model_out()});
    @(posedge clk);
    if (snap.ld === 1'b1) cnt = snap.din;
    else if (snap.enb === 1'b1) cnt = cnt + 3'd1;
    if (rs) begin
      m_active = 1'b0; m_load = 3'd0; m_err = 1'b0; m_seen = 0;
    end else if (!m_active) begin
      if (v) begin
        m_active = 1'b1; m_cyc = 1; m_load = ld; m_wraps = int'(w);
        m_err = 1'b0; m_seen = 0; m_done_cyc = (w == 8'd0) ? 2 : -1;
      end
    end else if (m_cyc == m_done_cyc) begin
      m_active = 1'b0;
    end else if (ab) begin
      m_active = 1'b0;
    end else begin
      if (m_cyc >= 2) begin
        if (int'(cv) != (int'(m_load) + m_cyc - 2) % 8) m_err = 1'b1;
        if (tv) begin
          if (m_seen < 255) m_seen++;
          if (m_seen == m_wraps) m_done_cyc = m_cyc + 1;
        end
      end
      m_cyc++;
    end
    cyc_n++;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, -1);
  endtask

  function automatic vec_t mk(bit v, bit [2:0] load, bit [7:0] wraps, bit ab, bit rs,
                              bit ready, bit bsy, bit ld, bit enb, bit dn, bit er,
                              int seen, int c);
    vec_t t;
    t.v = v; t.load = load; t.wraps = wraps; t.ab = ab; t.rs = rs;
    t.ready = ready; t.busy = bsy; t.ld = ld; t.enb = enb; t.done = dn; t.err = er;
    t.seen = seen; t.cnt = c;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[17];
    outs_t rst_o;
    bit    got;

    // cmd_load=5, cmd_wraps=2 with a correct counter; row 2 is cycle 0.
    tbl[0]  = mk(0,0,0,0,1, 1,0,0,0,0,0,0,-1);
    tbl[1]  = mk(0,0,0,0,0, 1,0,0,0,0,0,0,-1);
    tbl[2]  = mk(1,5,2,0,0, 1,0,0,0,0,0,0,-1);
    tbl[3]  = mk(0,0,0,0,0, 0,1,1,1,0,0,0,-1);
    tbl[4]  = mk(0,0,0,0,0, 0,1,0,1,0,0,0,5);
    tbl[5]  = mk(0,0,0,0,0, 0,1,0,1,0,0,0,6);
    tbl[6]  = mk(0,0,0,0,0, 0,1,0,1,0,0,0,7);
    tbl[7]  = mk(0,0,0,0,0, 0,1,0,1,0,0,1,0);
    tbl[8]  = mk(0,0,0,0,0, 0,1,0,1,0,0,1,1);
    tbl[9]  = mk(0,0,0,0,0, 0,1,0,1,0,0,1,2);
    tbl[10] = mk(1,3,1,0,0, 0,1,0,1,0,0,1,3);
    tbl[11] = mk(0,0,0,0,0, 0,1,0,1,0,0,1,4);
    tbl[12] = mk(0,0,0,0,0, 0,1,0,1,0,0,1,5);
    tbl[13] = mk(0,0,0,0,0, 0,1,0,1,0,0,1,6);
    tbl[14] = mk(0,0,0,0,0, 0,1,0,1,0,0,1,7);
    tbl[15] = mk(0,0,0,0,0, 0,1,0,0,1,0,2,0);
    tbl[16] = mk(0,0,0,0,0, 1,0,0,0,0,0,2,0);

    rst_o = '0;
    rst_o.ready = 1'b1;

    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1, -1);
    mdl_chk = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].load, tbl[i].wraps, tbl[i].ab, tbl[i].rs, -1);
      chkv($sformatf("tbl%0d.outs", i),
           {17'b0, snap.ready, snap.busy, snap.ld, snap.enb, snap.done, snap.err, snap.seen},
           {17'b0, tbl[i].ready, tbl[i].busy, tbl[i].ld, tbl[i].enb, tbl[i].done, tbl[i].err,
            8'(tbl[i].seen)});
      if (tbl[i].cnt >= 0) chkv($sformatf("tbl%0d.cnt", i), {29'b0, snap_cnt}, 32'(tbl[i].cnt));
    end

    // cmd_load=7, cmd_wraps=1: tc in cycle 2, done in cycle 3, counter rests at 0.
    step(1'b1, 3'd7, 8'd1, 1'b0, 1'b0, -1);
    idle();
    idle();
    chkv("w1.cnt_c2", {29'b0, snap_cnt}, 32'd7);
    idle();
    chkv("w1.done_c3", {31'b0, snap.done}, 32'd1);
    idle();
    chkv("w1.ready_c4", {31'b0, snap.ready}, 32'd1);
    chkv("w1.cnt_end", {29'b0, snap_cnt}, 32'd0);

    // cmd_wraps=0: LOAD in cycle 1, done in cycle 2 with the counter disabled.
    step(1'b1, 3'd3, 8'd0, 1'b0, 1'b0, -1);
    idle();
    chkv("w0.ld_c1", {31'b0, snap.ld}, 32'd1);
    idle();
    chkv("w0.done_enb_c2", {30'b0, snap.done, snap.enb}, 32'd2);
    idle();
    chkv("w0.ready_c3", {31'b0, snap.ready}, 32'd1);

    // Counter skips 6 -> 0 in cycle 3.
    step(1'b1, 3'd5, 8'd2, 1'b0, 1'b0, -1);
    idle();
    idle();
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 0);
    chkv("skip.err_c3", {31'b0, snap.err}, 32'd0);
    idle();
    chkv("skip.err_c4", {31'b0, snap.err}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      idle();
      if (snap.done === 1'b1) got = 1'b1;
    end
    chkv("skip.done_seen", {31'b0, got}, 32'd1);
    chkv("skip.err_at_done", {31'b0, snap.err}, 32'd1);
    idle();
    chkv("skip.err_idle", {30'b0, snap.err, snap.ready}, 32'd3);
    step(1'b1, 3'd2, 8'd0, 1'b0, 1'b0, -1);
    chkv("skip.err_accept", {31'b0, snap.err}, 32'd1);
    idle();
    chkv("skip.err_cleared", {31'b0, snap.err}, 32'd0);
    idle();
    idle();

    // Abort in cycle 6 of a 3-wrap run; cmd_valid in cycle 4 is ignored.
    step(1'b1, 3'd5, 8'd3, 1'b0, 1'b0, -1);
    idle();
    idle();
    idle();
    step(1'b1, 3'd1, 8'd0, 1'b0, 1'b0, -1);
    idle();
    chkv("abort.din_kept", {29'b0, snap.din}, 32'd5);
    step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, -1);
    idle();
    chkv("abort.c7", {26'b0, snap.ready, snap.busy, snap.enb, snap.done, snap.ld, snap.err},
         {26'b0, 6'b100000});
    chkv("abort.seen", {24'b0, snap.seen}, 32'd1);
    idle();
    chkv("abort.no_done", {31'b0, snap.done}, 32'd0);

    // Reset in the middle of a run.
    step(1'b1, 3'd2, 8'd4, 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) idle();
    step(1'b0, 3'd0, 8'd0, 1'b0, 1'b1, -1);
    idle();
    chkv("midreset.outs", {15'b0, snap}, {15'b0, rst_o});

    // Randomized traffic with occasional counter faults, aborts and resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 4)),
           ($urandom % 40) == 0, ($urandom % 300) == 0,
           (($urandom % 50) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer that drives the load/enable side of the 3-bit `counter` block, the controlling end of its `ld_enb`/`data_in`/`count_enb` interface. It accepts a command (start value, number of terminal counts to run), loads the counter, enables counting until the requested number of `tc` pulses has been seen, then stops and reports done. While running it keeps a shadow model of the expected `count_out` and flags any divergence, so it acts as both driver and in-line checker. It sits beside `counter` in the same clock domain.

## Interface
- `CNT_W`, 3, width of `data_in`/`count_out`
- `WRAP_W`, 8, width of the wrap-count field and of `wraps_seen`

- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_load`  in  CNT_W  start value for the counter
- `cmd_wraps`  in  WRAP_W  number of `tc` pulses to run for
- `abort`  in  1  stop the current run
- `ld_enb`  out  1  counter load strobe
- `data_in`  out  CNT_W  counter load value
- `count_enb`  out  1  counter enable
- `count_out`  in  CNT_W  counter value
- `tc`  in  1  terminal count, high when `count_out` == all-ones
- `busy`  out  1  high in LOAD, RUN and DONE
- `done`  out  1  one-cycle pulse at end of run
- `err`  out  1  sticky mismatch flag
- `wraps_seen`  out  WRAP_W  `tc` pulses counted in the current run

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered and decoded from state and datapath registers.
- IDLE: `cmd_ready`=1. When `cmd_valid`=1:
  - latch `cmd_load` and `cmd_wraps`;
  - clear `err` and `wraps_seen`;
  - go to LOAD.
- LOAD, one cycle: `ld_enb`=1, `data_in`=latched load value, `count_enb`=1 (load has priority in the counter).
  - Set the shadow `exp` to the load value.
  - If latched wraps == 0, go to DONE; otherwise go to RUN.
- RUN: `ld_enb`=0, `count_enb`=1, `data_in` holds the load value.
  - Every cycle, compare `count_out` with `exp`. On mismatch set `err`, which stays set until the next command is accepted.
  - `exp` <= `exp`+1, modulo 2^CNT_W (wraps 7->0).
  - When `tc`=1, increment `wraps_seen`. If the new value equals latched wraps, go to DONE.
- DONE, one cycle: `done`=1, `count_enb`=0, then go to IDLE.
- `abort`=1 in LOAD or RUN: next state is IDLE, `ld_enb`/`count_enb` drop to 0, no `done` pulse, `err` and `wraps_seen` are held. `abort` is ignored in IDLE and DONE.
- `cmd_valid` outside IDLE is ignored; there is no queuing.
- `wraps_seen` saturates at all-ones.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `ld_enb`=0, `count_enb`=0, `data_in`=0, `done`=0, `err`=0, `busy`=0, `wraps_seen`=0, `cmd_ready`=1 from the next cycle. Reset mid-run behaves the same; the counter is simply left at its current value.
- Cycle numbering: accept in cycle 0 (`cmd_valid`&`cmd_ready`).
  - Cycle 1: LOAD, `ld_enb`=1.
  - Cycle 2: first RUN cycle, `count_out` is expected to equal `cmd_load`.
- The edge that ends the final-`tc` cycle still counts the counter once, because `count_enb` was high during that cycle. The counter therefore rests at 0 after a run.
- `done` is high exactly one cycle after the final-`tc` cycle. `cmd_ready` returns the cycle after `done`.
- A compare only happens in RUN cycles. `tc` outside RUN is ignored.

## Test plan
- Reset, then hold: all outputs match their reset values, `cmd_ready`=1, no `ld_enb`/`count_enb` activity.
- `cmd_load`=5, `cmd_wraps`=2 with a correct counter:
  - `ld_enb` in cycle 1;
  - `count_out` 5,6,7,0..7 over cycles 2-12;
  - `tc` in cycles 4 and 12;
  - `done` in cycle 13, `wraps_seen`=2, `err`=0, idle in cycle 14.
- `cmd_load`=7, `cmd_wraps`=1: `tc` in cycle 2, `done` in cycle 3, counter ends at 0.
- `cmd_wraps`=0: LOAD in cycle 1, `done` in cycle 2, `count_enb` never high in RUN.
- Counter forced to skip a value (6->0 at cycle 3, `cmd_load`=5): `err`=1 from cycle 4 and stays high through `done`; it clears only on the next accepted command.
- `abort` in cycle 6 of a 3-wrap run: IDLE in cycle 7, `count_enb`=0, no `done`, `wraps_seen`=1. A `cmd_valid` presented in cycle 4 is ignored. A second `rst_n`=0 mid-run returns all outputs to their reset values.
